alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational riscv_alu between two requesters, e.g. the datapath and a debug/test port, over a valid/ready handshake. It performs round-robin arbitration, registers the ALU operands, and captures the ALU result into a per-requester response register. It screens out unassigned alu_fun codes, flagging them as errors without a meaningful result. It sits between the requesters and the riscv_alu instance, which drives alu_result back combinationally.

Parameters:
DATA_W, 32, operand/result width
ILLEGAL_MASK, 16'hDC00, bit n set means alu_fun==n is unassigned (codes 10,11,12,14,15)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
r0_valid  in  1  requester 0 has an op
r0_ready  out  1  requester 0 op accepted this cycle when high with r0_valid
r0_fun  in  4  requester 0 alu_fun code
r0_a  in  DATA_W  requester 0 srcA
r0_b  in  DATA_W  requester 0 srcB
r0_rsp_valid  out  1  requester 0 response available
r0_rsp_ready  in  1  requester 0 takes response
r0_result  out  DATA_W  requester 0 result
r0_err  out  1  requester 0 last op had an illegal code
r1_*  (same seven signals and meanings as r0_*, for requester 1)
alu_fun  out  4  to riscv_alu
alu_srcA  out  DATA_W  to riscv_alu
alu_srcB  out  DATA_W  to riscv_alu
alu_result  in  DATA_W  from riscv_alu, combinational
busy  out  1  state != IDLE
owner  out  1  requester of current/last op

Behaviour:
- Reset (RST high at an edge):
  - state=IDLE, prio=0 (requester 0 favoured), owner=0.
  - alu_fun/alu_srcA/alu_srcB=0.
  - rX_result=0, rX_err=0, rX_rsp_valid=0.
- RST overrides all other inputs. Reset mid-op abandons the op; no response is produced.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant, combinational from the valids:
    - only r0_valid: r0_ready=1
    - only r1_valid: r1_ready=1
    - both: ready goes to the requester indexed by prio
    - neither: both readies 0.
  - At most one ready is high. Readies are 0 in EXEC and RESP.
  - Accept edge (valid&ready): load alu_fun/srcA/srcB from the winner's fun/a/b, set owner=winner, state->EXEC.
- EXEC (exactly 1 cycle):
  - ALU ports are held from registers.
  - At the edge, if ILLEGAL_MASK[alu_fun]: rOwner_result<=0, rOwner_err<=1.
  - Otherwise: rOwner_result<=alu_result, rOwner_err<=0.
  - The non-owner's result and err are untouched. state->RESP.
- RESP:
  - rOwner_rsp_valid=1 (registered, asserted from the EXEC->RESP edge).
  - Held with result stable until rOwner_rsp_ready=1 at an edge. Then: rsp_valid->0, prio<=~owner, state->IDLE.
  - rsp_ready high early still costs at least 1 RESP cycle.
- Latency: accept at edge E0, rsp_valid high after edge E1 (E0+1 cycle). Minimum 3 cycles per op; no new accept before return to IDLE.
- ALU ports keep their last operands after EXEC until the next accept, so no toggling when idle.
- rX_result/rX_err persist after the response until overwritten by that requester's next op.
- Operands pass unmodified; shift amount interpretation (srcB[4:0]) belongs to riscv_alu.
- Requesters must hold fun/a/b stable while valid&!ready. Dropping valid before the grant is legal and leaves no side effect.
- Only one requester: it gets back-to-back service, 3 cycles/op; prio still toggles.
- Starvation bound: a waiting requester is served next after at most one op by the other.

Test Plan:
- Single op: after reset, r0 add (fun 0) 25+26 -> r0_ready high that cycle; r0_rsp_valid high 2 cycles later; r0_result=0x00000033, r0_err=0.
- Contention: after reset, r0 sub (8) 25-26 and r1 xor (4) 0x0000AAAA^0x00005555, both valid -> r0 served first, result 0xFFFFFFFF; then r1, result 0x0000FFFF. Repeat both-valid -> r0 first again (prio toggled to 0 after r1).
- Backpressure: r1 sltu (3) 0x8000FF00<5, r1_rsp_ready low 5 cycles while r0_valid high -> r1_rsp_valid held, r1_result=0 stable, r0_ready=0 throughout. Release -> r0 slt (2), same operands, returns 1.
- Illegal code: r0 fun 15, srcA=0x0000FF00, srcB=0x00000FFF -> r0_result=0, r0_err=1. Next r0 or (6) 0xAAAA|0x5555 -> 0x0000FFFF, err=0.
- Reset mid-op: assert RST during EXEC -> busy=0, all rsp_valid=0, results 0, no response. Then r1 sra (13) 0x8000FF00, 0x85 -> r1_result=0xFC0007F8.
- Shift/lui pass-through: r0 srl (5) 0x0000FF00, 0x85 -> 0x000007F8; r0 sll (1), same operands -> 0x001FE000. ALU ports stay stable across idle cycles.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester, ALU and status signals of the two-port ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              r0_valid;
    logic              r0_ready;
    logic [3:0]        r0_fun;
    logic [DATA_W-1:0] r0_a;
    logic [DATA_W-1:0] r0_b;
    logic              r0_rsp_valid;
    logic              r0_rsp_ready;
    logic [DATA_W-1:0] r0_result;
    logic              r0_err;

    logic              r1_valid;
    logic              r1_ready;
    logic [3:0]        r1_fun;
    logic [DATA_W-1:0] r1_a;
    logic [DATA_W-1:0] r1_b;
    logic              r1_rsp_valid;
    logic              r1_rsp_ready;
    logic [DATA_W-1:0] r1_result;
    logic              r1_err;

    logic [3:0]        alu_fun;
    logic [DATA_W-1:0] alu_srcA;
    logic [DATA_W-1:0] alu_srcB;
    logic [DATA_W-1:0] alu_result;

    logic              busy;
    logic              owner;

    // Arbiter side
    modport slave (
        input  r0_valid, r0_fun, r0_a, r0_b, r0_rsp_ready,
        output r0_ready, r0_rsp_valid, r0_result, r0_err,
        input  r1_valid, r1_fun, r1_a, r1_b, r1_rsp_ready,
        output r1_ready, r1_rsp_valid, r1_result, r1_err,
        output alu_fun, alu_srcA, alu_srcB,
        input  alu_result,
        output busy, owner
    );

    // Requester / ALU side
    modport master (
        output r0_valid, r0_fun, r0_a, r0_b, r0_rsp_ready,
        input  r0_ready, r0_rsp_valid, r0_result, r0_err,
        output r1_valid, r1_fun, r1_a, r1_b, r1_rsp_ready,
        input  r1_ready, r1_rsp_valid, r1_result, r1_err,
        input  alu_fun, alu_srcA, alu_srcB,
        output alu_result,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int          DATA_W       = 32,
    parameter logic [15:0] ILLEGAL_MASK = 16'hDC00
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    alu_arbiter_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_prio;
    logic              r_owner;
    logic [3:0]        r_alu_fun;
    logic [DATA_W-1:0] r_alu_srca;
    logic [DATA_W-1:0] r_alu_srcb;
    logic [DATA_W-1:0] r_result0;
    logic [DATA_W-1:0] r_result1;
    logic              r_err0;
    logic              r_err1;
    logic              r_rsp_valid0;
    logic              r_rsp_valid1;

    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic              w_winner;
    logic              w_rsp_done;
    logic              w_illegal;
    logic [DATA_W-1:0] w_exec_result;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Readies only ever rise for a valid requester, so a ready is an accept.
    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_accept    = 1'b0;
        w_winner    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.r0_valid && (!bus.r1_valid || !r_prio)) begin
                    w_ready0 = 1'b1;
                end else if (bus.r1_valid) begin
                    w_ready1 = 1'b1;
                end
                w_winner = w_ready1;
                if (w_ready0 || w_ready1) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                w_rsp_done = r_owner ? bus.r1_rsp_ready : bus.r0_rsp_ready;
                if (w_rsp_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_illegal     = ILLEGAL_MASK[r_alu_fun];
    assign w_exec_result = w_illegal ? '0 : bus.alu_result;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_alu_fun    <= '0;
            r_alu_srca   <= '0;
            r_alu_srcb   <= '0;
            r_result0    <= '0;
            r_result1    <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner    <= w_winner;
                r_alu_fun  <= w_winner ? bus.r1_fun : bus.r0_fun;
                r_alu_srca <= w_winner ? bus.r1_a   : bus.r0_a;
                r_alu_srcb <= w_winner ? bus.r1_b   : bus.r0_b;
            end
            if (r_state == c_ST_EXEC) begin
                if (r_owner) begin
                    r_result1    <= w_exec_result;
                    r_err1       <= w_illegal;
                    r_rsp_valid1 <= 1'b1;
                end else begin
                    r_result0    <= w_exec_result;
                    r_err0       <= w_illegal;
                    r_rsp_valid0 <= 1'b1;
                end
            end
            // Handing priority to the other side bounds its wait to one op.
            if (w_rsp_done) begin
                r_prio <= ~r_owner;
                if (r_owner) begin
                    r_rsp_valid1 <= 1'b0;
                end else begin
                    r_rsp_valid0 <= 1'b0;
                end
            end
        end
    end

    assign bus.r0_ready     = w_ready0;
    assign bus.r1_ready     = w_ready1;
    assign bus.r0_rsp_valid = r_rsp_valid0;
    assign bus.r1_rsp_valid = r_rsp_valid1;
    assign bus.r0_result    = r_result0;
    assign bus.r1_result    = r_result1;
    assign bus.r0_err       = r_err0;
    assign bus.r1_err       = r_err1;
    assign bus.alu_fun      = r_alu_fun;
    assign bus.alu_srcA     = r_alu_srca;
    assign bus.alu_srcB     = r_alu_srcb;
    assign bus.busy         = (r_state != c_ST_IDLE);
    assign bus.owner        = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed plus randomized bench for alu_arbiter with an ALU stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DATA_W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    alu_arbiter_if #(.DATA_W(DATA_W)) bus ();

    alu_arbiter #(
        .DATA_W       (DATA_W),
        .ILLEGAL_MASK (16'hDC00)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_prio;
    logic [31:0] m_res [2];
    bit          m_err [2];

    // Behaviour of the shared ALU; unassigned codes return junk on purpose.
    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'd0:    return a + b;
            4'd8:    return a - b;
            4'd1:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd13:   return $signed(a) >>> b[4:0];
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd9:    return a;
            default: return a ^ ~b ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [3:0] f);
        return (f == 4'd10) || (f == 4'd11) || (f == 4'd12) || (f == 4'd14) || (f == 4'd15);
    endfunction

    always_comb bus.alu_result = alu_model(bus.alu_fun, bus.alu_srcA, bus.alu_srcB);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_results();
        check("r0_result", bus.r0_result, m_res[0]);
        check("r1_result", bus.r1_result, m_res[1]);
        check("r0_err",    bus.r0_err,    m_err[0]);
        check("r1_err",    bus.r1_err,    m_err[1]);
    endtask

    task automatic model_reset();
        m_prio   = 1'b0;
        m_res[0] = '0;
        m_res[1] = '0;
        m_err[0] = 1'b0;
        m_err[1] = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        bus.r0_rsp_ready = 1'b0;
        bus.r1_rsp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
    endtask

    // Runs one full transaction; entered #1 after an edge with the DUT idle.
    // delay==0 raises rsp_ready before RESP; delay>0 holds it low that many cycles.
    task automatic do_op(input bit v0, input logic [3:0] f0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [3:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                         input int delay, input int idle);
        int          w;
        logic [3:0]  wf;
        logic [31:0] wa, wb;
        bus.r0_valid = v0; bus.r0_fun = f0; bus.r0_a = a0; bus.r0_b = b0;
        bus.r1_valid = v1; bus.r1_fun = f1; bus.r1_a = a1; bus.r1_b = b1;
        w  = (v0 && v1) ? int'(m_prio) : (v0 ? 0 : 1);
        wf = (w == 1) ? f1 : f0;
        wa = (w == 1) ? a1 : a0;
        wb = (w == 1) ? b1 : b0;
        #1;
        check("grant_r0_ready", bus.r0_ready, w == 0);
        check("grant_r1_ready", bus.r1_ready, w == 1);
        @(posedge CLK); #1;
        if (w == 1) bus.r1_valid = 1'b0; else bus.r0_valid = 1'b0;
        if (delay == 0) begin
            if (w == 1) bus.r1_rsp_ready = 1'b1; else bus.r0_rsp_ready = 1'b1;
        end
        check("exec_busy",     bus.busy, 1);
        check("exec_owner",    bus.owner, w);
        check("exec_r0_ready", bus.r0_ready, 0);
        check("exec_r1_ready", bus.r1_ready, 0);
        check("exec_alu_fun",  bus.alu_fun, wf);
        check("exec_alu_srcA", bus.alu_srcA, wa);
        check("exec_alu_srcB", bus.alu_srcB, wb);
        check("exec_rsp_valid", (w == 1) ? bus.r1_rsp_valid : bus.r0_rsp_valid, 0);
        @(posedge CLK); #1;
        m_res[w] = is_illegal(wf) ? 32'd0 : alu_model(wf, wa, wb);
        m_err[w] = is_illegal(wf);
        check("resp_valid_owner", (w == 1) ? bus.r1_rsp_valid : bus.r0_rsp_valid, 1);
        check("resp_valid_other", (w == 1) ? bus.r0_rsp_valid : bus.r1_rsp_valid, 0);
        check_results();
        for (int i = 0; i < delay; i++) begin
            @(posedge CLK); #1;
            check("hold_rsp_valid", (w == 1) ? bus.r1_rsp_valid : bus.r0_rsp_valid, 1);
            check("hold_r0_ready", bus.r0_ready, 0);
            check("hold_r1_ready", bus.r1_ready, 0);
            check("hold_busy", bus.busy, 1);
            check_results();
        end
        if (delay > 0) begin
            if (w == 1) bus.r1_rsp_ready = 1'b1; else bus.r0_rsp_ready = 1'b1;
        end
        @(posedge CLK); #1;
        bus.r0_rsp_ready = 1'b0;
        bus.r1_rsp_ready = 1'b0;
        m_prio = (w == 0);
        check("done_rsp_valid", (w == 1) ? bus.r1_rsp_valid : bus.r0_rsp_valid, 0);
        check("done_busy", bus.busy, 0);
        check_results();
        if (idle > 0) begin
            bus.r0_valid = 1'b0;
            bus.r1_valid = 1'b0;
            for (int i = 0; i < idle; i++) begin
                @(posedge CLK); #1;
                check("idle_alu_fun",  bus.alu_fun, wf);
                check("idle_alu_srcA", bus.alu_srcA, wa);
                check("idle_alu_srcB", bus.alu_srcB, wb);
                check("idle_busy",     bus.busy, 0);
            end
        end
    endtask

    initial begin
        bus.r0_valid = 1'b0; bus.r0_fun = '0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_rsp_ready = 1'b0;
        bus.r1_valid = 1'b0; bus.r1_fun = '0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_rsp_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_busy",     bus.busy, 0);
        check("rst_owner",    bus.owner, 0);
        check("rst_alu_fun",  bus.alu_fun, 0);
        check("rst_alu_srcA", bus.alu_srcA, 0);
        check("rst_alu_srcB", bus.alu_srcB, 0);
        check("rst_r0_rsp_valid", bus.r0_rsp_valid, 0);
        check("rst_r1_rsp_valid", bus.r1_rsp_valid, 0);
        check("rst_r0_ready", bus.r0_ready, 0);
        check("rst_r1_ready", bus.r1_ready, 0);
        check_results();

        // Single op: add
        do_op(1, 4'd0, 32'd25, 32'd26, 0, 4'd0, 32'd0, 32'd0, 0, 0);
        check("add_result", bus.r0_result, 32'h0000_0033);

        // Contention, then repeat both-valid after r1 returns priority to r0
        do_reset();
        do_op(1, 4'd8, 32'd25, 32'd26, 1, 4'd4, 32'h0000_AAAA, 32'h0000_5555, 0, 0);
        check("sub_result", bus.r0_result, 32'hFFFF_FFFF);
        do_op(0, 4'd8, 32'd25, 32'd26, 1, 4'd4, 32'h0000_AAAA, 32'h0000_5555, 0, 0);
        check("xor_result", bus.r1_result, 32'h0000_FFFF);
        do_op(1, 4'd8, 32'd25, 32'd26, 1, 4'd4, 32'h0000_AAAA, 32'h0000_5555, 1, 0);

        // Backpressure on r1 while r0 waits, then r0 slt on the same operands
        do_op(1, 4'd2, 32'h8000_FF00, 32'd5, 1, 4'd3, 32'h8000_FF00, 32'd5, 5, 0);
        check("sltu_result", bus.r1_result, 32'd0);
        do_op(1, 4'd2, 32'h8000_FF00, 32'd5, 0, 4'd0, 32'd0, 32'd0, 0, 0);
        check("slt_result", bus.r0_result, 32'd1);

        // Illegal code then a legal op
        do_op(1, 4'd15, 32'h0000_FF00, 32'h0000_0FFF, 0, 4'd0, 32'd0, 32'd0, 1, 0);
        check("illegal_err", bus.r0_err, 1);
        do_op(1, 4'd6, 32'h0000_AAAA, 32'h0000_5555, 0, 4'd0, 32'd0, 32'd0, 0, 0);
        check("or_result", bus.r0_result, 32'h0000_FFFF);

        // Shifts with idle cycles between
        do_op(1, 4'd5, 32'h0000_FF00, 32'h85, 0, 4'd0, 32'd0, 32'd0, 0, 3);
        check("srl_result", bus.r0_result, 32'h0000_07F8);
        do_op(1, 4'd1, 32'h0000_FF00, 32'h85, 0, 4'd0, 32'd0, 32'd0, 2, 3);
        check("sll_result", bus.r0_result, 32'h001F_E000);

        // Reset asserted while the op is in EXEC
        bus.r0_valid = 1'b1; bus.r0_fun = 4'd0; bus.r0_a = 32'd7; bus.r0_b = 32'd9;
        @(posedge CLK); #1;
        bus.r0_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        check("midrst_busy", bus.busy, 0);
        check("midrst_r0_rsp_valid", bus.r0_rsp_valid, 0);
        check("midrst_r1_rsp_valid", bus.r1_rsp_valid, 0);
        check("midrst_alu_srcA", bus.alu_srcA, 0);
        check_results();
        @(posedge CLK); #1;
        check("midrst_no_rsp", bus.r0_rsp_valid, 0);
        check("midrst_still_idle", bus.busy, 0);
        do_op(0, 4'd0, 32'd0, 32'd0, 1, 4'd13, 32'h8000_FF00, 32'h85, 0, 0);
        check("sra_result", bus.r1_result, 32'hFC00_07F8);

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            do_op(v0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                  v1, 4'($urandom_range(0, 15)), $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
